pipe_latch_elastic: RTL and testbench
=====================================

PIPE_LATCH_ELASTIC -- requirements
Module: pipe_latch_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (range 1..256).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width in bits (range 2..32).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  discard all held entries this cycle.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_ready  output  1  latch can accept a word.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload (packed stage bundle: pc_plus_4, wsel, control bits, ...).
REQ-009 SHALL have port out_valid  output  1  out_data holds a live entry.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out_data.
REQ-011 SHALL have port out_data  output  WIDTH  head entry payload.
REQ-012 SHALL have port occupancy  output  2  entries held (0..2).
REQ-013 SHALL have port stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-014 SHALL hold two storage entries, head and skid, plus a 2-bit count register; no other payload state.
REQ-015 SHALL drive in_ready = (count != 2), out_valid = (count != 0), out_data = head, occupancy = count; all from registers only, no input-to-output combinational path.
REQ-016 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, evaluated each cycle.
REQ-017 SHALL, at count 0: push -> head <= in_data, count 1; no push -> no change.
REQ-018 SHALL, at count 1: push & pop -> head <= in_data, count stays 1; push only -> skid <= in_data, count 2; pop only -> count 0.
REQ-019 SHALL, at count 2: pop -> head <= skid, count 1; no pop -> no change (push impossible since in_ready = 0).
REQ-020 SHALL preserve strict FIFO order; zero-bubble throughput of one word per cycle when out_ready stays high; latency in_valid to out_valid exactly 1 cycle from empty.
REQ-021 SHALL give flush priority over push and pop: count <= 0 next cycle, any word pushed in the flush cycle discarded, head/skid contents unchanged but invisible.
REQ-022 SHALL increment stall_cnt by 1 in each cycle with out_valid = 1 and out_ready = 0, including flush cycles, saturating at 2^CNT_W - 1 (no wrap).
REQ-023 SHALL never present a stale entry: after count drops to 0, out_valid = 0 until a new push completes.

Reset
REQ-024 SHALL, in any cycle with RST = 1, set count <= 0, head <= 0, skid <= 0, stall_cnt <= 0, overriding flush, push and pop.
REQ-025 SHALL present, from the first cycle after RST deasserts, out_valid = 0, in_ready = 1, occupancy = 0, out_data = 0, stall_cnt = 0.
REQ-026 SHALL ignore in_valid during RST-high cycles (word not stored), even though in_ready reads 1 there.
REQ-027 SHALL, on reset asserted mid-operation with count = 2, drop both entries; no entry reappears after release.

Verification
REQ-028 Bench SHALL cover streaming: WIDTH=32, in_valid=1 with data 1,2,3,...,8 on consecutive cycles, out_ready=1 -> out_data 1..8 on cycles 1..8, out_valid continuous, occupancy 1, stall_cnt 0.
REQ-029 Bench SHALL cover back-pressure fill: push 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready 0, third offer 0xC held off; raise out_ready -> outputs 0xA, 0xB, 0xC in order, stall_cnt equals the number of out_ready-low cycles with out_valid=1.
REQ-030 Bench SHALL cover flush with simultaneous push: occupancy 2, flush=1 and in_valid=1 data 0x55 same cycle -> next cycle occupancy 0, out_valid 0; 0x55 never appears.
REQ-031 Bench SHALL cover stall saturation: CNT_W=2, out_valid=1, out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3.
REQ-032 Bench SHALL cover reset mid-operation: occupancy 2 with stall_cnt 5, RST=1 for 1 cycle with in_valid=1 -> after release occupancy 0, out_data 0, stall_cnt 0, in_ready 1, offered word not stored.

Source files
------------

// File: rtl/pipe_latch_elastic.sv
// pipe_latch_elastic: two-entry skid latch with flush and a saturating back-pressure counter
module pipe_latch_elastic #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);
   logic [1:0]       count;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] skid;
   logic             push;
   logic             pop;
   assign in_ready  = count != 2'd2;
   assign out_valid = count != 2'd0;
   assign out_data  = head;
   assign occupancy = count;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   // Entry storage, occupancy and stall counter; flush only clears occupancy, payload stays but becomes invisible
   always_ff @(posedge CLK) begin
      if (RST) begin
         count     <= 2'd0;
         head      <= '0;
         skid      <= '0;
         stall_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (flush)
            count <= 2'd0;
         else if (count == 2'd0) begin
            if (push) begin
               head  <= in_data;
               count <= 2'd1;
            end
         end else if (count == 2'd1) begin
            if (push && pop)
               head <= in_data;
            else if (push) begin
               skid  <= in_data;
               count <= 2'd2;
            end else if (pop)
               count <= 2'd0;
         end else if (pop) begin
            head  <= skid;
            count <= 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_pipe_latch_elastic.sv
// tb_pipe_latch_elastic: directed checks of the elastic latch, including a CNT_W=2 instance for saturation
module tb_pipe_latch_elastic;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid, in_ready_b, out_valid_b;
   logic [31:0] out_data, out_data_b;
   logic [1:0]  occupancy, occupancy_b;
   logic [15:0] stall_a;
   logic [1:0]  stall_b;
   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   pipe_latch_elastic #(.WIDTH(32), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_a));

   pipe_latch_elastic #(.WIDTH(32), .CNT_W(2)) dut_b (
      .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .occupancy(occupancy_b), .stall_cnt(stall_b));

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      tests++; if (stall_a !== 16'd0) begin fails++; $display("FAIL reset_stall got %0d exp 0", stall_a); end
   endtask

   task automatic test_streaming();
      do_reset();
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_valid = 1'b1; in_data = k;
         step();
         tests++; if (out_data !== k) begin fails++; $display("FAIL stream_data[%0d] got %0d exp %0d", k, out_data, k); end
         tests++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin fails++; $display("FAIL stream_valid[%0d] got v=%b occ=%0d exp v=1 occ=1", k, out_valid, occupancy); end
      end
      in_valid = 1'b0;
      step();
      tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin fails++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
      tests++; if (stall_a !== 16'd0) begin fails++; $display("FAIL stream_stall got %0d exp 0", stall_a); end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 1'b1; in_data = 32'hA;
      step();
      in_data = 32'hB;
      step();
      tests++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready); end
      in_data = 32'hC;
      step();
      tests++; if (occupancy !== 2'd2 || out_data !== 32'hA) begin fails++; $display("FAIL bp_hold got occ=%0d data=%h exp occ=2 data=a", occupancy, out_data); end
      out_ready = 1'b1;
      step();
      tests++; if (out_data !== 32'hB || occupancy !== 2'd1) begin fails++; $display("FAIL bp_second got data=%h occ=%0d exp data=b occ=1", out_data, occupancy); end
      step();
      tests++; if (out_data !== 32'hC || out_valid !== 1'b1) begin fails++; $display("FAIL bp_third got data=%h v=%b exp data=c v=1", out_data, out_valid); end
      in_valid = 1'b0;
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got v=%b exp 0", out_valid); end
      tests++; if (stall_a !== 16'd2) begin fails++; $display("FAIL bp_stall got %0d exp 2", stall_a); end
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1'b1; in_data = 32'h11;
      step();
      in_data = 32'h22;
      step();
      tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL flush_pre got occ=%0d exp 2", occupancy); end
      flush = 1'b1; in_data = 32'h55;
      step();
      flush = 1'b0; in_valid = 1'b0;
      tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_clear got occ=%0d v=%b rdy=%b exp occ=0 v=0 rdy=1", occupancy, out_valid, in_ready); end
      out_ready = 1'b1;
      step();
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_stale got v=%b exp 0", out_valid); end
      in_valid = 1'b1; in_data = 32'h66;
      step();
      in_valid = 1'b0;
      tests++; if (out_data !== 32'h66 || occupancy !== 2'd1) begin fails++; $display("FAIL flush_next got data=%h occ=%0d exp data=66 occ=1", out_data, occupancy); end
      tests++; if (stall_a !== 16'd2) begin fails++; $display("FAIL flush_stall got %0d exp 2", stall_a); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_b [6];
      exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      do_reset();
      in_valid = 1'b1; in_data = 32'h9;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         tests++; if (stall_b !== exp_b[k]) begin fails++; $display("FAIL sat_b[%0d] got %0d exp %0d", k, stall_b, exp_b[k]); end
         tests++; if (stall_a !== 16'(k + 1)) begin fails++; $display("FAIL sat_a[%0d] got %0d exp %0d", k, stall_a, k + 1); end
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      in_valid = 1'b1; in_data = 32'h1;
      step();
      in_data = 32'h2;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      tests++; if (occupancy !== 2'd2 || stall_a !== 16'd5) begin fails++; $display("FAIL midrst_pre got occ=%0d stall=%0d exp occ=2 stall=5", occupancy, stall_a); end
      RST = 1'b1; in_valid = 1'b1; in_data = 32'h77;
      step();
      RST = 1'b0; in_valid = 1'b0;
      tests++; if (occupancy !== 2'd0 || out_data !== 32'd0 || stall_a !== 16'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL midrst_post got occ=%0d data=%h stall=%0d rdy=%b exp 0 0 0 1", occupancy, out_data, stall_a, in_ready); end
      step();
      tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin fails++; $display("FAIL midrst_nostore got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_saturation();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
